// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer melody path: note periods, note index
// encoding, sequencer state encoding and the note-to-period lookup.
package buzzer_pkg;

  // Tone periods in system clocks for each playable note.
  localparam logic [17:0] PERIOD_DO = 18'd190839;
  localparam logic [17:0] PERIOD_RE = 18'd170067;
  localparam logic [17:0] PERIOD_MI = 18'd151514;
  localparam logic [17:0] PERIOD_FA = 18'd143265;
  localparam logic [17:0] PERIOD_SO = 18'd127550;
  localparam logic [17:0] PERIOD_LA = 18'd113635;
  localparam logic [17:0] PERIOD_XI = 18'd101213;

  // A buffered command is {note[2:0], beats[3:0]}.
  localparam int CMD_W = 7;

  typedef enum logic [2:0] {
    NOTE_REST = 3'd0,
    NOTE_DO   = 3'd1,
    NOTE_RE   = 3'd2,
    NOTE_MI   = 3'd3,
    NOTE_FA   = 3'd4,
    NOTE_SO   = 3'd5,
    NOTE_LA   = 3'd6,
    NOTE_XI   = 3'd7
  } note_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } seq_state_e;

  // Map a note index to its period; a rest keeps the current period so the
  // tone generator is not disturbed while silent.
  function automatic logic [17:0] period_lookup(input logic [2:0] note,
                                                input logic [17:0] cur_period);
    logic [17:0] p;
    p = cur_period;
    case (note)
      NOTE_DO: p = PERIOD_DO;
      NOTE_RE: p = PERIOD_RE;
      NOTE_MI: p = PERIOD_MI;
      NOTE_FA: p = PERIOD_FA;
      NOTE_SO: p = PERIOD_SO;
      NOTE_LA: p = PERIOD_LA;
      NOTE_XI: p = PERIOD_XI;
      default: p = cur_period;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/note_sequencer_cmd_fifo.sv
// Synchronous command FIFO for the note sequencer. Show-ahead read: rdata_o
// always presents the oldest entry; pop_i consumes it on the clock edge.
// Simultaneous push and pop are allowed at any non-full occupancy.
module cmd_fifo
  import buzzer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CMD_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (count_q == CNT_FULL);
  assign empty_o   = (count_q == '0);
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;
  assign rdata_o   = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Melody sequencer feeding the buzzer tone generator. Commands {note, beats}
// are buffered in cmd_fifo and played for exactly beats*BEAT_CYCLES clocks.
// Build option NOTE_SEQ_GAP_EN: adds a silent GAP of GAP_CYCLES clocks after
// every note; without it consecutive notes play back-to-back.
module note_sequencer
  import buzzer_pkg::*;
#(
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_250_000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        system_clock,
  input  logic        system_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_note,
  input  logic [3:0]  cmd_beats,
  output logic [17:0] tone_period,
  output logic        tone_en,
  output logic        note_done,
  output logic        busy
);

  localparam int BW = $clog2(BEAT_CYCLES);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);

`ifdef NOTE_SEQ_GAP_EN
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  logic [GW-1:0] gap_cnt_q;
  logic [GW-1:0] gap_cnt_d;
`endif

  seq_state_e    state_q;
  seq_state_e    state_d;
  logic [BW-1:0] beat_cnt_q;
  logic [BW-1:0] beat_cnt_d;
  logic [3:0]    beats_left_q;
  logic [3:0]    beats_left_d;
  logic [17:0]   period_q;
  logic [17:0]   period_d;
  logic          tone_en_q;
  logic          tone_en_d;
  logic          note_done_q;
  logic          note_done_d;
  logic          busy_q;
  logic          busy_d;

  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [6:0]    fifo_rdata_s;
  logic          push_s;
  logic          pop_s;
  logic          idle_req_s;
  logic          end_note_s;
  logic          load_s;
  logic [2:0]    head_note_s;
  logic [3:0]    head_beats_s;

  // Zero-beat commands are acknowledged but never stored.
  assign cmd_ready    = !fifo_full_s;
  assign push_s       = cmd_valid && !fifo_full_s && (cmd_beats != 4'd0);
  assign head_note_s  = fifo_rdata_s[6:4];
  assign head_beats_s = fifo_rdata_s[3:0];

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk_i   (system_clock),
    .rst_i   (system_reset),
    .push_i  (push_s),
    .wdata_i ({cmd_note, cmd_beats}),
    .pop_i   (pop_s),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Next-state decode: beat timing, end-of-note handling and command loading.
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    beats_left_d = beats_left_q;
    period_d     = period_q;
    tone_en_d    = tone_en_q;
    idle_req_s   = 1'b0;
    end_note_s   = 1'b0;
`ifdef NOTE_SEQ_GAP_EN
    gap_cnt_d    = gap_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        idle_req_s = 1'b1;
      end
      ST_PLAY: begin
        if (beat_cnt_q == BEAT_LAST) begin
          beat_cnt_d = '0;
          if (beats_left_q == 4'd1) begin
`ifdef NOTE_SEQ_GAP_EN
            state_d   = ST_GAP;
            tone_en_d = 1'b0;
            gap_cnt_d = '0;
`else
            end_note_s = 1'b1;
`endif
          end else begin
            beats_left_d = beats_left_q - 4'd1;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + BW'(1);
        end
      end
`ifdef NOTE_SEQ_GAP_EN
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          end_note_s = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
`endif
      default: begin
        state_d   = ST_IDLE;
        tone_en_d = 1'b0;
      end
    endcase

    // A waiting command is loaded on the same edge a note ends, so there is
    // no idle cycle between buffered notes.
    load_s = (idle_req_s || end_note_s) && !fifo_empty_s;
    pop_s  = load_s;

    if (load_s) begin
      state_d      = ST_PLAY;
      period_d     = period_lookup(head_note_s, period_q);
      beats_left_d = head_beats_s;
      beat_cnt_d   = '0;
      tone_en_d    = (head_note_s != NOTE_REST);
    end else if (end_note_s) begin
      state_d   = ST_IDLE;
      tone_en_d = 1'b0;
    end else begin
      state_d = state_d;
    end

    // Registered outputs are computed from next-state values so they line up
    // with the cycle they describe.
    note_done_d = (state_d == ST_PLAY) && (beats_left_d == 4'd1) &&
                  (beat_cnt_d == BEAT_LAST);
    busy_d      = (state_d != ST_IDLE) || push_s;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      state_q      <= ST_IDLE;
      beat_cnt_q   <= '0;
      beats_left_q <= 4'd0;
      period_q     <= PERIOD_DO;
      tone_en_q    <= 1'b0;
      note_done_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef NOTE_SEQ_GAP_EN
      gap_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      beats_left_q <= beats_left_d;
      period_q     <= period_d;
      tone_en_q    <= tone_en_d;
      note_done_q  <= note_done_d;
      busy_q       <= busy_d;
`ifdef NOTE_SEQ_GAP_EN
      gap_cnt_q    <= gap_cnt_d;
`endif
    end
  end

  assign tone_period = period_q;
  assign tone_en     = tone_en_q;
  assign note_done   = note_done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer. Each accepted command pushes its
// expected play window (start cycle, note_done cycle, tone_en, period) into a
// scoreboard; a monitor compares the DUT outputs against it every cycle.
module tb_note_sequencer;

  localparam int B_CYC = 10;
  localparam int G_CYC = 3;
  localparam int DEPTH = 4;
`ifdef NOTE_SEQ_GAP_EN
  localparam int GAP_EFF = G_CYC;
`else
  localparam int GAP_EFF = 0;
`endif

  logic        system_clock = 1'b0;
  logic        system_reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_note;
  logic [3:0]  cmd_beats;
  logic [17:0] tone_period;
  logic        tone_en;
  logic        note_done;
  logic        busy;

  typedef struct {
    int          start;
    int          done;
    logic        en;
    logic [17:0] period;
  } exp_t;

  exp_t        sb_q[$];
  int          edge_cnt    = 0;
  int          errors      = 0;
  int          checks      = 0;
  int          free_edge   = 0;
  int          done_pulses = 0;
  int          last_start  = 0;
  logic [17:0] model_period;

  note_sequencer #(
    .BEAT_CYCLES (B_CYC),
    .GAP_CYCLES  (G_CYC),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .system_clock (system_clock),
    .system_reset (system_reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_note     (cmd_note),
    .cmd_beats    (cmd_beats),
    .tone_period  (tone_period),
    .tone_en      (tone_en),
    .note_done    (note_done),
    .busy         (busy)
  );

  always #5 system_clock = ~system_clock;

  function automatic logic [17:0] ref_period(input logic [2:0] n);
    case (n)
      3'd1:    return 18'd190839;
      3'd2:    return 18'd170067;
      3'd3:    return 18'd151514;
      3'd4:    return 18'd143265;
      3'd5:    return 18'd127550;
      3'd6:    return 18'd113635;
      3'd7:    return 18'd101213;
      default: return 18'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Record the expected play window for a command accepted at edge acc_edge.
  task automatic model_accept(input logic [2:0] n, input logic [3:0] b, input int acc_edge);
    exp_t r;
    if (b != 4'd0) begin
      if (n != 3'd0) model_period = ref_period(n);
      r.start    = (acc_edge + 1 > free_edge) ? acc_edge + 1 : free_edge;
      r.done     = r.start + int'(b) * B_CYC - 1;
      r.en       = (n != 3'd0);
      r.period   = model_period;
      free_edge  = r.done + 1 + GAP_EFF;
      last_start = r.start;
      sb_q.push_back(r);
    end
  endtask

  // Offer one command (called at a falling edge); holds cmd_valid until taken.
  task automatic send(input logic [2:0] n, input logic [3:0] b);
    int waitc;
    waitc     = 0;
    cmd_valid = 1'b1;
    cmd_note  = n;
    cmd_beats = b;
    while (cmd_ready !== 1'b1 && waitc < 500) begin
      @(negedge system_clock);
      waitc++;
    end
    chk("send_ready", 32'(cmd_ready), 32'd1);
    if (cmd_ready === 1'b1) model_accept(n, b, edge_cnt + 1);
    @(negedge system_clock);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((busy !== 1'b0 || sb_q.size() != 0) && n < limit) begin
      @(negedge system_clock);
      n++;
    end
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_sb_empty", 32'(sb_q.size()), 32'd0);
  endtask

  // Per-cycle monitor, sampling 2 time units after each rising edge.
  always begin
    @(posedge system_clock);
    edge_cnt = edge_cnt + 1;
    #2;
    chk("busy", 32'(busy), {31'd0, (sb_q.size() > 0) || (edge_cnt < free_edge)});
    if (sb_q.size() > 0 && edge_cnt >= sb_q[0].start) begin
      chk("tone_en", 32'(tone_en), 32'(sb_q[0].en));
      chk("tone_period", 32'(tone_period), 32'(sb_q[0].period));
      chk("note_done", 32'(note_done), {31'd0, edge_cnt == sb_q[0].done});
      if (edge_cnt == sb_q[0].done) void'(sb_q.pop_front());
    end else begin
      chk("silent_tone_en", 32'(tone_en), 32'd0);
      chk("silent_note_done", 32'(note_done), 32'd0);
    end
    if (note_done === 1'b1) done_pulses++;
  end

  initial begin
    int base;
    int guard;
    system_reset = 1'b1;
    cmd_valid    = 1'b0;
    cmd_note     = 3'd0;
    cmd_beats    = 4'd0;
    model_period = 18'd190839;
    repeat (3) @(negedge system_clock);
    system_reset = 1'b0;

    // Reset state
    chk("rst_tone_en", 32'(tone_en), 32'd0);
    chk("rst_period", 32'(tone_period), 32'd190839);
    chk("rst_note_done", 32'(note_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Single note MI x2
    base = done_pulses;
    send(3'd3, 4'd2);
    wait_idle(100);
    chk("single_done_pulses", 32'(done_pulses - base), 32'd1);

    // Back-to-back DO, SO
    send(3'd1, 4'd1);
    send(3'd5, 4'd1);
    wait_idle(100);

    // Full FIFO: six commands offered while the first plays
    base = done_pulses;
    send(3'd4, 4'd2);
    send(3'd1, 4'd1);
    send(3'd2, 4'd1);
    send(3'd3, 4'd1);
    send(3'd5, 4'd1);
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    send(3'd6, 4'd1);
    wait_idle(300);
    chk("full_done_pulses", 32'(done_pulses - base), 32'd6);

    // Rest, zero-beat, RE
    base = done_pulses;
    send(3'd0, 4'd1);
    send(3'd2, 4'd0);
    send(3'd2, 4'd1);
    wait_idle(100);
    chk("rest_done_pulses", 32'(done_pulses - base), 32'd2);

    // Reset five cycles into LA x3 with two commands queued
    send(3'd6, 4'd3);
    send(3'd1, 4'd1);
    send(3'd7, 4'd1);
    guard = 0;
    while (edge_cnt < last_start + 4 && guard < 100) begin
      @(negedge system_clock);
      guard++;
    end
    chk("pre_reset_tone_en", 32'(tone_en), 32'd1);
    system_reset = 1'b1;
    sb_q.delete();
    free_edge    = 0;
    model_period = 18'd190839;
    @(negedge system_clock);
    system_reset = 1'b0;
    chk("mid_rst_tone_en", 32'(tone_en), 32'd0);
    chk("mid_rst_period", 32'(tone_period), 32'd190839);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    base = done_pulses;
    repeat (40) @(negedge system_clock);
    chk("post_rst_done_pulses", 32'(done_pulses - base), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
